// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default sizes for the segmented data memory and
// its data-port arbiter.
//   arb_state_t : arbiter ownership state (IDLE, OWN0, OWN1)
//   *_DEFAULT   : default geometry / lock parameters
//   cnt_width() : bits needed to hold a counter value 0..max_val
package mem_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    localparam int NSEG_DEFAULT     = 6;
    localparam int RAMSIZE_DEFAULT  = 512;
    localparam int WIDTH_DEFAULT    = 32;
    localparam int LOCK_MAX_DEFAULT = 8;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_lock_timer.sv
// dmem_lock_timer: counts the cycles a bus lock has kept the other requester
// waiting and flags when the lock has run out.
// Ports:
//   clk    in  : clock
//   reset  in  : synchronous active-high reset
//   clear  in  : ownership ends or changes hands this cycle; restart from 0
//   count  in  : the locked-out requester is asserting req this cycle
//   expire out : counter has reached LOCK_MAX; owner must release now
module dmem_lock_timer
    import mem_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam int            CW    = cnt_width(LOCK_MAX);
    localparam logic [CW-1:0] LIMIT = CW'(LOCK_MAX);

    logic [CW-1:0] cnt;

    assign expire = (cnt == LIMIT);

    // NOTE: clocked state is written with <= so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (count && !expire) begin
            // saturate at LIMIT; the forced release clears it next cycle
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter for the data port of the segmented
// memory. Requester 0 is the pipeline MEM stage, requester 1 the
// loader/debug port. One transfer per cycle; completion one cycle later.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req/we/lock/a/wd 0,1: request, write, keep-ownership, address, write data
//   gnt0/1              : transfer accepted this cycle (combinational)
//   rvalid0/1, rd0/1    : completion pulse and read data (0 for writes)
//   err0/1              : address was out of range (valid with rvalid)
//   lock_err            : forced lock release this cycle (combinational)
//   mem_we/mem_a/mem_wd : shared memory data port (combinational)
//   mem_rd              : memory read data, combinational from mem_a
// Config macro DMEM_ARB_FIXED_PRIO_EN: when defined, idle ties always go to
// requester 0 and no round-robin state exists; otherwise round robin.
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int RAMSIZE  = RAMSIZE_DEFAULT,
    parameter int NSEG     = NSEG_DEFAULT,
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic             lock0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] wd0,
    input  logic             req1,
    input  logic             we1,
    input  logic             lock1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] wd1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rd0,
    output logic [WIDTH-1:0] rd1,
    output logic             err0,
    output logic             err1,
    output logic             lock_err,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    // one extra bit so RAMSIZE*NSEG itself is representable
    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(RAMSIZE * NSEG);

    arb_state_t state, state_next;
    logic       tie_pick1;
    logic       expire, clear, count;
    logic       in_range0, in_range1;

    assign in_range0 = ({1'b0, a0} < LIMIT);
    assign in_range1 = ({1'b0, a1} < LIMIT);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign tie_pick1 = 1'b0;
`else
    logic rr_last;

    // winner of a tie is the requester that did not win the last transfer
    assign tie_pick1 = ~rr_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b1;
        end else if (gnt0) begin
            rr_last <= 1'b0;
        end else if (gnt1) begin
            rr_last <= 1'b1;
        end
    end
`endif

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (expire) begin
                // lock ran out: only the waiting side may go this cycle
                gnt0 = (state == OWN1) & req0;
                gnt1 = (state == OWN0) & req1;
            end else begin
                case (state)
                    IDLE: begin
                        if (req0 && req1) begin
                            gnt1 = tie_pick1;
                            gnt0 = ~tie_pick1;
                        end else begin
                            gnt0 = req0;
                            gnt1 = req1;
                        end
                    end
                    OWN0:    gnt0 = req0;
                    OWN1:    gnt1 = req1;
                    default: ;
                endcase
            end
        end
    end

    assign lock_err = expire & ~reset;

    always_comb begin
        state_next = state;
        if (gnt0) begin
            state_next = lock0 ? OWN0 : IDLE;
        end else if (gnt1) begin
            state_next = lock1 ? OWN1 : IDLE;
        end else if (expire) begin
            state_next = IDLE;
        end
    end

    // restart the lock count whenever ownership ends or changes hands
    assign clear = (state_next != state) || (state_next == IDLE);
    assign count = ((state == OWN0) && req1) || ((state == OWN1) && req0);

    dmem_lock_timer #(
        .LOCK_MAX (LOCK_MAX)
    ) u_lock_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .count  (count),
        .expire (expire)
    );

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (gnt0) begin
            mem_we = we0 & in_range0;
            mem_a  = a0;
            mem_wd = wd0;
        end else if (gnt1) begin
            mem_we = we1 & in_range1;
            mem_a  = a1;
            mem_wd = wd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rd0     <= '0;
            rd1     <= '0;
            err0    <= 1'b0;
            err1    <= 1'b0;
        end else begin
            state   <= state_next;
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            rd0     <= (gnt0 && !we0 && in_range0) ? mem_rd : '0;
            rd1     <= (gnt1 && !we1 && in_range1) ? mem_rd : '0;
            err0    <= gnt0 && !in_range0;
            err1    <= gnt1 && !in_range1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter (LOCK_MAX=4). Grants,
// completion timing, lock_err and the memory port are checked cycle by cycle;
// read data / error flags go through per-requester scoreboard queues that a
// separate monitor drains on every rvalid.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] a0, wd0, a1, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, lock_err, mem_we;
    logic [31:0] rd0, rd1, mem_a, mem_wd, mem_rd;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } resp_t;

    resp_t q0[$];
    resp_t q1[$];
    resp_t e0, e1;
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .WIDTH(32), .RAMSIZE(512), .NSEG(6), .LOCK_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .a0(a0), .wd0(wd0),
        .req1(req1), .we1(we1), .lock1(lock1), .a1(a1), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rd0(rd0), .rd1(rd1), .err0(err0), .err1(err1), .lock_err(lock_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // memory model: unwritten words read as 0xA500_0000 | index
    bit [31:0] mem_model [4096];
    bit        written   [4096];

    assign mem_rd = written[mem_a[11:0]] ? mem_model[mem_a[11:0]]
                                         : (32'hA500_0000 | {20'd0, mem_a[11:0]});

    always @(posedge clk) begin
        if (mem_we) begin
            mem_model[mem_a[11:0]] <= mem_wd;
            written[mem_a[11:0]]   <= 1'b1;
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic r, input logic w, input logic l,
                          input logic [31:0] a, input logic [31:0] d);
        req0 = r; we0 = w; lock0 = l; a0 = a; wd0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic l,
                          input logic [31:0] a, input logic [31:0] d);
        req1 = r; we1 = w; lock1 = l; a1 = a; wd1 = d;
    endtask

    task automatic push0(input logic [31:0] rd, input logic err);
        q0.push_back('{rd: rd, err: err});
    endtask

    task automatic push1(input logic [31:0] rd, input logic err);
        q1.push_back('{rd: rd, err: err});
    endtask

    // check the combinational and completion outputs of the current cycle
    task automatic cyc(input string tag, input logic g0, input logic g1,
                       input logic v0, input logic v1, input logic le,
                       input logic mw, input logic [31:0] ma);
        @(negedge clk);
        check1({tag, ".gnt0"}, gnt0, g0);
        check1({tag, ".gnt1"}, gnt1, g1);
        check1({tag, ".rvalid0"}, rvalid0, v0);
        check1({tag, ".rvalid1"}, rvalid1, v1);
        check1({tag, ".lock_err"}, lock_err, le);
        check1({tag, ".mem_we"}, mem_we, mw);
        check32({tag, ".mem_a"}, mem_a, ma);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: every completion must match the oldest expectation
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (rvalid0 === 1'b1) begin
                if (q0.size() == 0) begin
                    check1("rv0_unexpected", rvalid0, 1'b0);
                end else begin
                    e0 = q0.pop_front();
                    check32("sb.rd0", rd0, e0.rd);
                    check1("sb.err0", err0, e0.err);
                end
            end
            if (rvalid1 === 1'b1) begin
                if (q1.size() == 0) begin
                    check1("rv1_unexpected", rvalid1, 1'b0);
                end else begin
                    e1 = q1.pop_front();
                    check32("sb.rd1", rd1, e1.rd);
                    check1("sb.err1", err1, e1.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic ex0, pv0, pv1;

    initial begin
        // reset with both requesters already asking: nothing may be granted
        reset = 1'b1;
        drive0(1, 0, 0, 32'h10, 0);
        drive1(1, 0, 0, 32'h20, 0);
        tick();
        cyc("rst", 0, 0, 0, 0, 0, 0, 32'h0);
        check32("rst.mem_wd", mem_wd, 32'h0);
        check32("rst.rd0", rd0, 32'h0);
        tick();
        reset = 1'b0;

        // 1: simultaneous reads after reset, req0 wins the first tie
        push0(32'hA500_0010, 0); push1(32'hA500_0020, 0);
        cyc("t1c0", 1, 0, 0, 0, 0, 0, 32'h10); tick();
        drive0(0, 0, 0, 0, 0);
        cyc("t1c1", 0, 1, 1, 0, 0, 0, 32'h20); tick();
        drive1(0, 0, 0, 0, 0);
        cyc("t1c2", 0, 0, 0, 1, 0, 0, 32'h0); tick();

        // 2: req1 writes 600, req0 reads it back
        drive1(1, 1, 0, 32'd600, 32'hDEAD_BEEF); push1(32'h0, 0);
        cyc("t2c0", 0, 1, 0, 0, 0, 1, 32'd600);
        check32("t2c0.mem_wd", mem_wd, 32'hDEAD_BEEF); tick();
        drive1(0, 0, 0, 0, 0);
        drive0(1, 0, 0, 32'd600, 0); push0(32'hDEAD_BEEF, 0);
        cyc("t2c1", 1, 0, 0, 1, 0, 0, 32'd600); tick();
        drive0(0, 0, 0, 0, 0);
        cyc("t2c2", 0, 0, 1, 0, 0, 0, 32'h0); tick();

        // 3: req0 locked sequence of three reads while req1 waits
        drive0(1, 0, 1, 32'h40, 0); push0(32'hA500_0040, 0);
        cyc("t3c0", 1, 0, 0, 0, 0, 0, 32'h40); tick();
        drive0(1, 0, 1, 32'h41, 0); push0(32'hA500_0041, 0);
        drive1(1, 0, 0, 32'h30, 0); push1(32'hA500_0030, 0);
        cyc("t3c1", 1, 0, 1, 0, 0, 0, 32'h41); tick();
        drive0(1, 0, 0, 32'h42, 0); push0(32'hA500_0042, 0);
        cyc("t3c2", 1, 0, 1, 0, 0, 0, 32'h42); tick();
        drive0(0, 0, 0, 0, 0);
        cyc("t3c3", 0, 1, 1, 0, 0, 0, 32'h30); tick();
        drive1(0, 0, 0, 0, 0);
        cyc("t3c4", 0, 0, 0, 1, 0, 0, 32'h0); tick();

        // 4: req0 never releases its lock; after 4 blocked cycles it is forced off
        drive0(1, 0, 1, 32'h50, 0);
        drive1(1, 0, 0, 32'h60, 0); push1(32'hA500_0060, 0);
        push0(32'hA500_0050, 0);
        cyc("t4c0", 1, 0, 0, 0, 0, 0, 32'h50); tick();
        for (int i = 1; i <= 4; i++) begin
            push0(32'hA500_0050, 0);
            cyc($sformatf("t4c%0d", i), 1, 0, 1, 0, 0, 0, 32'h50); tick();
        end
        cyc("t4c5", 0, 1, 1, 0, 1, 0, 32'h60); tick();
        drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
        cyc("t4c6", 0, 0, 0, 1, 0, 0, 32'h0); tick();
        // state must be IDLE: a lone req1 is granted immediately
        drive1(1, 0, 0, 32'h61, 0); push1(32'hA500_0061, 0);
        cyc("t4c7", 0, 1, 0, 0, 0, 0, 32'h61); tick();
        drive1(0, 0, 0, 0, 0);
        cyc("t4c8", 0, 0, 0, 1, 0, 0, 32'h0); tick();

        // 5: range boundary at RAMSIZE*NSEG = 3072, unsigned compare
        drive0(1, 1, 0, 32'd3072, 32'h1234_5678); push0(32'h0, 1);
        cyc("t5c0", 1, 0, 0, 0, 0, 0, 32'd3072); tick();
        drive0(1, 1, 0, 32'd3071, 32'hCAFE_F00D); push0(32'h0, 0);
        cyc("t5c1", 1, 0, 1, 0, 0, 1, 32'd3071); tick();
        drive0(1, 0, 0, 32'hFFFF_FFFF, 0); push0(32'h0, 1);
        cyc("t5c2", 1, 0, 1, 0, 0, 0, 32'hFFFF_FFFF); tick();
        drive0(1, 0, 0, 32'd3071, 0); push0(32'hCAFE_F00D, 0);
        cyc("t5c3", 1, 0, 1, 0, 0, 0, 32'd3071); tick();
        drive0(0, 0, 0, 0, 0);
        cyc("t5c4", 0, 0, 1, 0, 0, 0, 32'h0); tick();

        // 7: repeated ties (last winner was req0): alternate, or always req0
        drive0(1, 0, 0, 32'h70, 0);
        drive1(1, 0, 0, 32'h71, 0);
        pv0 = 1'b0; pv1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ex0 = FIXED ? 1'b1 : (i % 2 == 1);
            if (ex0) push0(32'hA500_0070, 0);
            else     push1(32'hA500_0071, 0);
            cyc($sformatf("t7c%0d", i), ex0, !ex0, pv0, pv1, 0, 0,
                ex0 ? 32'h70 : 32'h71);
            pv0 = ex0; pv1 = !ex0;
            tick();
        end
        drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
        cyc("t7d", 0, 0, pv0, pv1, 0, 0, 32'h0); tick();

        // 6: reset while OWN1 with a transfer in flight
        drive1(1, 0, 1, 32'h80, 0); push1(32'hA500_0080, 0);
        cyc("t6c0", 0, 1, 0, 0, 0, 0, 32'h80); tick();
        drive1(1, 0, 1, 32'h81, 0);
        drive0(1, 0, 0, 32'h90, 0);
        cyc("t6c1", 0, 1, 0, 1, 0, 0, 32'h81);
        #1 reset = 1'b1;
        #1 check1("t6_rst.gnt1", gnt1, 1'b0);
        check32("t6_rst.mem_a", mem_a, 32'h0);
        tick();
        cyc("t6r", 0, 0, 0, 0, 0, 0, 32'h0); tick();
        reset = 1'b0;
        drive1(1, 0, 0, 32'h81, 0);
        push0(32'hA500_0090, 0); push1(32'hA500_0081, 0);
        cyc("t6c2", 1, 0, 0, 0, 0, 0, 32'h90); tick();
        drive0(0, 0, 0, 0, 0);
        cyc("t6c3", 0, 1, 1, 0, 0, 0, 32'h81); tick();
        drive1(0, 0, 0, 0, 0);
        cyc("t6c4", 0, 0, 0, 1, 0, 0, 32'h0); tick();

        tick(); tick();
        check32("q0_drained", 32'(q0.size()), 32'd0);
        check32("q1_drained", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
